// File: rtl/shift_arb_pkg.sv
// Shared encodings for the shift arbiter: shifter op selects and FSM states.
package shift_arb_pkg;

    localparam logic [2:0] SH_SLL = 3'd0;
    localparam logic [2:0] SH_SRL = 3'd1;
    localparam logic [2:0] SH_SRA = 3'd2;
    localparam logic [2:0] SH_ROL = 3'd3;
    localparam logic [2:0] SH_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req scanning from last+1 with wrap.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (en && !found && req[i] && (i == (int'(last) + k) % N)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/shifter.sv
// Combinational 32-bit shifter: SLL/SRL/SRA/ROL/ROR, illegal selects give 0.
module shifter
    import shift_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    input  logic [2:0]  sel,
    output logic [31:0] y
);

    logic [63:0] rol_w;
    logic [63:0] ror_w;

    always_comb begin
        // Doubling the word makes both rotates a plain shift plus a slice.
        rol_w = {a, a} << shamt;
        ror_w = {a, a} >> shamt;
        case (sel)
            SH_SLL:  y = a << shamt;
            SH_SRL:  y = a >> shamt;
            SH_SRA:  y = $signed(a) >>> shamt;
            SH_ROL:  y = rol_w[63:32];
            SH_ROR:  y = ror_w[31:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one shifter between NREQ requesters.
// Define SHIFT_ARB_ERR_EN to add rsp_err and a saturating err_cnt.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [5*NREQ-1:0] req_shamt,
    input  logic [3*NREQ-1:0] req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_y,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
`ifdef SHIFT_ARB_ERR_EN
    ,
    output logic              rsp_err,
    output logic [7:0]        err_cnt
`endif
);

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]    a_q, a_d;
    logic [4:0]     shamt_q, shamt_d;
    logic [2:0]     sel_q, sel_d;
    logic [31:0]    rsp_y_q, rsp_y_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;
    logic [31:0]    pick_a;
    logic [4:0]     pick_shamt;
    logic [2:0]     pick_sel;
    logic [31:0]    shift_y;
    logic           accept;
`ifdef SHIFT_ARB_ERR_EN
    logic           illegal;
    logic           err_q, err_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
`endif

    // Gating with rst keeps req_ready low while reset is held.
    rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
        .req       (req_valid),
        .last      (last_q),
        .en        (state_q == ST_IDLE && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    shifter u_shifter (
        .a     (a_q),
        .shamt (shamt_q),
        .sel   (sel_q),
        .y     (shift_y)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef SHIFT_ARB_ERR_EN
    assign illegal   = (sel_q > SH_ROR);
    assign rsp_err   = err_q;
    assign err_cnt   = err_cnt_q;
`endif

    always_comb begin
        pick_a     = '0;
        pick_shamt = '0;
        pick_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                pick_a     = req_a[32*i +: 32];
                pick_shamt = req_shamt[5*i +: 5];
                pick_sel   = req_sel[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        shamt_d     = shamt_q;
        sel_d       = sel_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
`ifdef SHIFT_ARB_ERR_EN
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = pick_a;
                    shamt_d = pick_shamt;
                    sel_d   = pick_sel;
                    last_d  = grant_idx;
                    id_d    = grant_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef SHIFT_ARB_ERR_EN
                rsp_y_d = illegal ? 32'd0 : shift_y;
                err_d   = illegal;
`else
                rsp_y_d = shift_y;
`endif
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
`ifdef SHIFT_ARB_ERR_EN
                    if (err_q && err_cnt_q != 8'hFF)
                        err_cnt_d = err_cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            shamt_q     <= '0;
            sel_q       <= '0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SHIFT_ARB_ERR_EN
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            a_q         <= a_d;
            shamt_q     <= shamt_d;
            sel_q       <= sel_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef SHIFT_ARB_ERR_EN
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

endmodule
